// File: rtl/water_pkg.sv
// Shared types and defaults for the water-column LED level controller.
package water_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    FILL  = 2'b01,
    DRAIN = 2'b10,
    SEEK  = 2'b11
  } mode_t;

  localparam int unsigned ROWS_DEF  = 7;
  localparam int unsigned CELLS_DEF = 2;
  localparam int unsigned DIV_DEF   = 4;

  // Bits needed to hold a level count of 0..cap inclusive.
  function automatic int unsigned calc_lw(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/water_column_ctrl_step_prescaler.sv
// Divides clk down to a one-cycle step tick every DIV enabled cycles.
module step_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count only advances while enabled, so a pause resumes mid-period.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/water_column_ctrl.sv
// Level controller for the tank LED bar: one level count, stepped per tick,
// rendered as a thermometer with bit 0 at the bottom.
module water_column_ctrl
  import water_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned CELLS = CELLS_DEF,
  parameter int unsigned DIV   = DIV_DEF,
  parameter int unsigned LW    = calc_lw(ROWS * CELLS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [LW-1:0]           target,
  input  logic                    load,
  output logic [ROWS*CELLS-1:0]   lines,
  output logic [LW-1:0]           level,
  output logic                    full,
  output logic                    empty,
  output logic                    at_target,
  output logic                    spill
);

  localparam int unsigned CAP = ROWS * CELLS;
  localparam logic [LW-1:0] CAP_LW = LW'(CAP);

  logic          tick;
  mode_t         mode_e;
  logic [LW-1:0] tgt_clamp;
  logic [LW-1:0] level_q, level_d;
  logic          spill_q, spill_d;

  step_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  assign mode_e    = mode_t'(mode);
  assign tgt_clamp = (target > CAP_LW) ? CAP_LW : target;

  // Load wins over any tick in the same cycle; a tick under load is dropped.
  always_comb begin
    level_d = level_q;
    spill_d = 1'b0;
    if (load) begin
      level_d = tgt_clamp;
    end else if (tick) begin
      case (mode_e)
        FILL: begin
          if (level_q == CAP_LW) spill_d = 1'b1;
          else                   level_d = level_q + LW'(1);
        end
        DRAIN: begin
          if (level_q != '0) level_d = level_q - LW'(1);
        end
        SEEK: begin
          if (level_q < tgt_clamp)      level_d = level_q + LW'(1);
          else if (level_q > tgt_clamp) level_d = level_q - LW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      spill_q <= 1'b0;
    end else begin
      level_q <= level_d;
      spill_q <= spill_d;
    end
  end

  for (genvar i = 0; i < CAP; i++) begin : g_therm
    assign lines[i] = (LW'(i) < level_q);
  end

  assign level     = level_q;
  assign full      = (level_q == CAP_LW);
  assign empty     = (level_q == '0);
  assign at_target = (level_q == tgt_clamp);
  assign spill     = spill_q;

endmodule

// File: tb/tb_water_column_ctrl.sv
// Directed bench for water_column_ctrl at ROWS=7, CELLS=2, DIV=4 (CAP=14, LW=4).
module tb_water_column_ctrl;
  import water_pkg::*;

  logic        clk;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic [3:0]  target;
  logic        load;
  logic [13:0] lines;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        at_target;
  logic        spill;

  int errors;
  int checks;

  water_column_ctrl #(.ROWS(7), .CELLS(2), .DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .target    (target),
    .load      (load),
    .lines     (lines),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .at_target (at_target),
    .spill     (spill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = HOLD; target = 4'd0;
    step(1);
    reset = 1'b0;
  endtask

  // Load a level with en low so the prescaler stays at cnt=0.
  task automatic preload(input logic [3:0] v);
    target = v; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = HOLD; target = 4'd0;
    step(2);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (lines !== 14'h0000) begin errors++; $display("FAIL reset_lines got=%h exp=0000", lines); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (spill !== 1'b0) begin errors++; $display("FAIL reset_spill got=%b exp=0", spill); end
    checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL reset_at_target got=%b exp=1", at_target); end
    target = 4'd5; #1;
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL reset_at_target_t5 got=%b exp=0", at_target); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    apply_reset();
    mode = FILL; en = 1'b1;
    step(3);
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL fill_pre_tick got=%0d exp=0", level); end
    step(1);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL fill_first got=%0d exp=1", level); end
    checks++; if (lines !== 14'h0001) begin errors++; $display("FAIL fill_first_lines got=%h exp=0001", lines); end
    step(51);
    checks++; if (full !== 1'b0 || level !== 4'd13) begin errors++; $display("FAIL fill_55 got=%0d full=%b exp=13 full=0", level, full); end
    step(1);
    checks++; if (full !== 1'b1 || level !== 4'd14) begin errors++; $display("FAIL fill_full got=%0d full=%b exp=14 full=1", level, full); end
    checks++; if (lines !== 14'h3FFF) begin errors++; $display("FAIL fill_full_lines got=%h exp=3fff", lines); end
    step(3);
    checks++; if (spill !== 1'b0) begin errors++; $display("FAIL spill_early got=%b exp=0", spill); end
    step(1);
    checks++; if (spill !== 1'b1 || level !== 4'd14) begin errors++; $display("FAIL spill_pulse got=%b lvl=%0d exp=1 lvl=14", spill, level); end
    step(1);
    checks++; if (spill !== 1'b0) begin errors++; $display("FAIL spill_width got=%b exp=0", spill); end
    mode = HOLD;
  endtask

  task automatic test_drain();
    logic any_change;
    apply_reset();
    preload(4'd9);
    checks++; if (level !== 4'd9) begin errors++; $display("FAIL drain_load got=%0d exp=9", level); end
    mode = DRAIN; en = 1'b1;
    step(4);
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL drain_first got=%0d exp=8", level); end
    step(32);
    checks++; if (level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0d empty=%b exp=0 empty=1", level, empty); end
    any_change = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (spill !== 1'b0 || level !== 4'd0) any_change = 1'b1;
    end
    checks++; if (any_change !== 1'b0) begin errors++; $display("FAIL drain_floor got=%b exp=0", any_change); end
    mode = HOLD;
  endtask

  task automatic test_seek();
    apply_reset();
    preload(4'd3);
    mode = SEEK; target = 4'd6; en = 1'b1;
    #1;
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL seek_not_at got=%b exp=0", at_target); end
    step(8);
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL seek_mid got=%0d exp=5", level); end
    step(4);
    checks++; if (level !== 4'd6 || at_target !== 1'b1) begin errors++; $display("FAIL seek_reach got=%0d at=%b exp=6 at=1", level, at_target); end
    step(8);
    checks++; if (level !== 4'd6) begin errors++; $display("FAIL seek_hold got=%0d exp=6", level); end
    target = 4'd15;
    #1;
    checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL seek_clamp_at got=%b exp=0", at_target); end
    step(32);
    checks++; if (level !== 4'd14 || at_target !== 1'b1) begin errors++; $display("FAIL seek_clamp got=%0d at=%b exp=14 at=1", level, at_target); end
    step(8);
    checks++; if (level !== 4'd14 || spill !== 1'b0) begin errors++; $display("FAIL seek_clamp_hold got=%0d spill=%b exp=14 spill=0", level, spill); end
    mode = HOLD;
  endtask

  task automatic test_load_priority();
    apply_reset();
    preload(4'd10);
    mode = FILL; en = 1'b1;
    step(3);
    target = 4'd5; load = 1'b1;
    step(1);
    load = 1'b0;
    checks++; if (level !== 4'd5 || spill !== 1'b0) begin errors++; $display("FAIL load_prio got=%0d spill=%b exp=5 spill=0", level, spill); end
    step(3);
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL load_prio_hold got=%0d exp=5", level); end
    step(1);
    checks++; if (level !== 4'd6) begin errors++; $display("FAIL load_prio_next got=%0d exp=6", level); end
    mode = HOLD;
  endtask

  task automatic test_enable_freeze();
    apply_reset();
    preload(4'd4);
    mode = FILL; en = 1'b1;
    step(2);
    en = 1'b0;
    step(10);
    checks++; if (level !== 4'd4) begin errors++; $display("FAIL freeze_level got=%0d exp=4", level); end
    en = 1'b1;
    step(1);
    checks++; if (level !== 4'd4) begin errors++; $display("FAIL freeze_resume1 got=%0d exp=4", level); end
    step(1);
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL freeze_resume2 got=%0d exp=5", level); end
    mode = HOLD;
  endtask

  task automatic test_async_reset();
    apply_reset();
    preload(4'd12);
    checks++; if (level !== 4'd12 || lines !== 14'h0FFF) begin errors++; $display("FAIL areset_pre got=%0d lines=%h exp=12 lines=0fff", level, lines); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (lines !== 14'h0000 || empty !== 1'b1) begin errors++; $display("FAIL areset_clear lines=%h empty=%b exp=0000 empty=1", lines, empty); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL areset_level got=%0d exp=0", level); end
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = HOLD; target = 4'd0;
    test_reset();
    test_fill();
    test_drain();
    test_seek();
    test_load_priority();
    test_enable_freeze();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/water_column_ctrl.md
# water_column_ctrl

Parametrised water-column level controller driving the tank's LED bar display. It holds a single level count of 0..CAP, where CAP = ROWS*CELLS, and moves it one cell per prescaled tick according to a mode input: fill, drain, hold, or seek-to-target. It renders the count as a thermometer bus, one bit per LED, with bit 0 at the bottom. It replaces the fixed 7-row, 2-cell, fill/drain-only row chain and adds:

- arbitrary geometry;
- step-rate control;
- target seeking;
- immediate load;
- status flags.

## Interface
Parameters:
- ROWS, 7, number of display rows.
- CELLS, 2, LEDs per row; CAP = ROWS*CELLS.
- DIV, 4, clk cycles per step tick; must be at least 1.
- LW, derived as $clog2(CAP+1), width of level, target and pos.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  run enable; when low, the prescaler and the level are frozen.
- mode  in  2  00 HOLD, 01 FILL, 10 DRAIN, 11 SEEK.
- target  in  LW  seek/load destination; values above CAP are clamped to CAP.
- load  in  1  single-cycle pulse: level <= clamp(target) at the next edge.
- lines  out  CAP  thermometer; lines[i] = (i < level).
- level  out  LW  current level count.
- full  out  1  level == CAP.
- empty  out  1  level == 0.
- at_target  out  1  level == clamp(target).
- spill  out  1  one-cycle pulse: a FILL tick occurred while full.

## Operation
- Prescaler:
  - Counter cnt runs 0..DIV-1 while en=1 and wraps to 0.
  - tick = en && (cnt == DIV-1).
  - A mode change does not reset cnt.
- Level update at each edge, in priority order:
  1. load=1: level <= clamp(target). This is independent of en and tick, and any tick in the same cycle is discarded.
  2. tick and FILL: level+1, saturating at CAP. If level is already CAP, pulse spill instead.
  3. tick and DRAIN: level-1, saturating at 0.
  4. tick and SEEK: step one toward clamp(target); no change when equal.
  5. HOLD, or no tick: no change.
- Outputs derive from the level register:
  - lines, full, empty and at_target decode level combinationally. No extra delay stage.
  - spill is a registered pulse.
- Arithmetic:
  - level is unsigned LW bits; it never holds a value above CAP.
  - The clamp compares target against CAP, which is held as an LW-bit constant.
- Boundaries:
  - DRAIN at empty: silent, no flag.
  - SEEK with target > CAP: seeks to CAP.
  - en=0 with load=1: load still applies.

## Timing
- Reset values: cnt=0, level=0, lines=0, full=0, empty=1, spill=0. at_target = (clamp(target) == 0).
- Reset is asynchronous: asserting it mid-step clears everything immediately, with no partial step. After release, the first tick arrives DIV cycles after the first edge with en=1.
- A tick sampled at edge k gives a new level after edge k, so lines and flags change in the same cycle. Latency from tick to display is 1 edge.
- Load to display: 1 edge.
- spill is high for exactly the one cycle after the offending tick edge.
- Steady FILL from empty with en=1 reaches full after CAP*DIV cycles.

## Structure
- Package water_pkg holds:
  - mode_t enum {HOLD, FILL, DRAIN, SEEK};
  - the parameter defaults;
  - a function to compute LW.
- Sub-module step_prescaler has params DIV; ports clk, reset, en, tick.
- Thermometer decode is a generate loop inside the top. Flags use simple compares.

## Test plan
All scenarios use ROWS=7, CELLS=2, DIV=4, so CAP=14 and LW=4.
- Fill from empty:
  - Stimulus: reset, then en=1, mode=FILL.
  - Response: level=1 after 4 cycles; lines=14'h0001. full=1 at cycle 56 with lines=14'h3FFF. One further tick gives spill=1 for exactly 1 cycle.
- Drain:
  - Stimulus: load target=9, then mode=DRAIN.
  - Response: level 9 steps to 8 to 0 at one step per 4 cycles; empty=1. Further ticks cause no change and no spill.
- Seek:
  - Stimulus: level=3, mode=SEEK, target=6. Then target=15.
  - Response: level reaches 6 in 3 ticks, then at_target=1 and no further change. With target=15 it seeks to 14 and stops.
- Load priority:
  - Stimulus: load=1, target=5 in the same cycle as a FILL tick at level=10.
  - Response: level=5; spill=0.
- Enable freeze:
  - Stimulus: drop en for 10 cycles mid-period with cnt=2.
  - Response: level is unchanged, and the next tick arrives 1 cycle after en returns.
- Async reset:
  - Stimulus: assert reset between edges at level=12.
  - Response: lines=0 and empty=1 before the next edge.
